// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller and the datapath
// blocks it steers (next-PC mux, register-file write muxes, ALU).
package mc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXE_R  = 4'd3,
      ST_EXE_I  = 4'd4,
      ST_MEMADR = 4'd5,
      ST_MEMRD  = 4'd6,
      ST_MEMWR  = 4'd7,
      ST_WB_ALU = 4'd8,
      ST_WB_MEM = 4'd9,
      ST_BRANCH = 4'd10,
      ST_JUMP   = 4'd11,
      ST_JR     = 4'd12
   } state_t;

   // opcodes, instruction[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes, instruction[5:0]
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   localparam logic [1:0] NPC_PC4  = 2'd0;
   localparam logic [1:0] NPC_BR   = 2'd1;
   localparam logic [1:0] NPC_JMP  = 2'd2;
   localparam logic [1:0] NPC_RS   = 2'd3;

   localparam logic [1:0] RDST_RT  = 2'd0;
   localparam logic [1:0] RDST_RD  = 2'd1;
   localparam logic [1:0] RDST_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU  = 2'd0;
   localparam logic [1:0] M2R_MEM  = 2'd1;
   localparam logic [1:0] M2R_PC4  = 2'd2;

   typedef struct packed {
      logic is_rtype;
      logic is_addu;
      logic is_subu;
      logic is_jr;
      logic is_ori;
      logic is_lui;
      logic is_lw;
      logic is_sw;
      logic is_beq;
      logic is_j;
      logic is_jal;
      logic illegal;
   } instr_class_t;

   // states in which the controller waits on the memory handshake
   function automatic logic is_wait_state(state_t s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decode of the op/funct fields held in IR.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0]   op_i,
   input  logic [5:0]   funct_i,
   output instr_class_t cls_o
);

   logic r_type;

   assign r_type = (op_i == OP_RTYPE);

   // class flags; anything not matched is flagged illegal
   always_comb begin
      cls_o          = '0;
      cls_o.is_rtype = r_type;
      cls_o.is_addu  = r_type && (funct_i == FN_ADDU);
      cls_o.is_subu  = r_type && (funct_i == FN_SUBU);
      cls_o.is_jr    = r_type && (funct_i == FN_JR);
      cls_o.is_ori   = (op_i == OP_ORI);
      cls_o.is_lui   = (op_i == OP_LUI);
      cls_o.is_lw    = (op_i == OP_LW);
      cls_o.is_sw    = (op_i == OP_SW);
      cls_o.is_beq   = (op_i == OP_BEQ);
      cls_o.is_j     = (op_i == OP_J);
      cls_o.is_jal   = (op_i == OP_JAL);
      cls_o.illegal  = !(cls_o.is_addu | cls_o.is_subu | cls_o.is_jr  |
                         cls_o.is_ori  | cls_o.is_lui  | cls_o.is_lw  |
                         cls_o.is_sw   | cls_o.is_beq  | cls_o.is_j   |
                         cls_o.is_jal);
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  IDLE   (0) | after reset, all enables off
//  FETCH  (1) | read instruction; on mem_ready load IR and PC+4
//  DECODE (2) | classify op/funct, flag illegal instructions
//  EXE_R  (3) | ALU on rs,rt (addu/subu)
//  EXE_I  (4) | ALU on rs,zero-extended immediate (ori/lui)
//  MEMADR (5) | effective address rs + sign-extended offset
//  MEMRD  (6) | data read, wait for mem_ready
//  MEMWR  (7) | data write, wait for mem_ready
//  WB_ALU (8) | write ALU result to rd (R) or rt (I)
//  WB_MEM (9) | write load data to rt
//  BRANCH(10) | compare rs,rt; take branch target when zero
//  JUMP  (11) | jump target; jal also links PC+4 into $31
//  JR    (12) | PC <- rs
//
// Handshake-dependent enables (FETCH irwr/pcwr, BRANCH pcwr, timeout err)
// must react in the same cycle as mem_ready/zero, so outputs are decoded
// combinationally from the state register rather than registered.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       irwr,
   output logic       pcwr,
   output logic [1:0] npc_sel,
   output logic       regwr,
   output logic [1:0] regdst,
   output logic [1:0] memtoreg,
   output logic       extcon,
   output logic       alusrc,
   output logic [2:0] aluop,
   output logic       err,
   output logic [3:0] state
);

   state_t       state_q, state_d;
   logic [3:0]   tmo_cnt_q, tmo_cnt_d;
   logic         mem_stall;
   logic         tmo_hit;
   instr_class_t cls;

   mc_decode u_decode (
      .op_i    (op),
      .funct_i (funct),
      .cls_o   (cls)
   );

   assign mem_stall = is_wait_state(state_q) && !mem_ready;
   // the stall cycle that completes MEM_TIMEOUT consecutive waits aborts
   assign tmo_hit   = mem_stall && (tmo_cnt_q == MEM_TIMEOUT - 4'd1);
   assign state     = state_q;

   // state and timeout-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // stall counter: a stall keeps the state, so any other cycle clears it
   always_comb begin
      tmo_cnt_d = '0;
      if (mem_stall && !tmo_hit) begin
         tmo_cnt_d = tmo_cnt_q + 4'd1;
      end
   end

   // next-state sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) begin
               state_d = ST_DECODE;
            end else if (tmo_hit) begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (cls.illegal)                   state_d = ST_FETCH;
            else if (cls.is_addu | cls.is_subu) state_d = ST_EXE_R;
            else if (cls.is_jr)                 state_d = ST_JR;
            else if (cls.is_ori | cls.is_lui)   state_d = ST_EXE_I;
            else if (cls.is_lw | cls.is_sw)     state_d = ST_MEMADR;
            else if (cls.is_beq)                state_d = ST_BRANCH;
            else                                state_d = ST_JUMP;
         end
         ST_EXE_R:  state_d = ST_WB_ALU;
         ST_EXE_I:  state_d = ST_WB_ALU;
         ST_MEMADR: state_d = cls.is_sw ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (mem_ready)    state_d = ST_WB_MEM;
            else if (tmo_hit) state_d = ST_FETCH;
         end
         ST_MEMWR: begin
            if (mem_ready || tmo_hit) state_d = ST_FETCH;
         end
         ST_WB_ALU: state_d = ST_FETCH;
         ST_WB_MEM: state_d = ST_FETCH;
         ST_BRANCH: state_d = ST_FETCH;
         ST_JUMP:   state_d = ST_FETCH;
         ST_JR:     state_d = ST_FETCH;
         default:   state_d = ST_IDLE;
      endcase
   end

   // datapath enables per state
   always_comb begin
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      irwr     = 1'b0;
      pcwr     = 1'b0;
      npc_sel  = NPC_PC4;
      regwr    = 1'b0;
      regdst   = RDST_RT;
      memtoreg = M2R_ALU;
      extcon   = 1'b0;
      alusrc   = 1'b0;
      aluop    = ALU_ADD;
      err      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_rd = 1'b1;
            irwr   = mem_ready;
            pcwr   = mem_ready;
            err    = tmo_hit;
         end
         ST_DECODE: begin
            extcon = cls.is_lw | cls.is_sw | cls.is_beq;
            err    = cls.illegal;
         end
         ST_EXE_R: begin
            aluop = cls.is_subu ? ALU_SUB : ALU_ADD;
         end
         ST_EXE_I: begin
            alusrc = 1'b1;
            aluop  = cls.is_lui ? ALU_LUI : ALU_OR;
         end
         ST_MEMADR: begin
            alusrc = 1'b1;
            extcon = 1'b1;
         end
         ST_MEMRD: begin
            mem_rd = 1'b1;
            err    = tmo_hit;
         end
         ST_MEMWR: begin
            mem_wr = 1'b1;
            err    = tmo_hit;
         end
         ST_WB_ALU: begin
            regwr  = 1'b1;
            regdst = cls.is_rtype ? RDST_RD : RDST_RT;
         end
         ST_WB_MEM: begin
            regwr    = 1'b1;
            memtoreg = M2R_MEM;
         end
         ST_BRANCH: begin
            aluop   = ALU_SUB;
            extcon  = 1'b1;
            npc_sel = NPC_BR;
            pcwr    = zero;
         end
         ST_JUMP: begin
            pcwr    = 1'b1;
            npc_sel = NPC_JMP;
            if (cls.is_jal) begin
               regwr    = 1'b1;
               regdst   = RDST_R31;
               memtoreg = M2R_PC4;
            end
         end
         ST_JR: begin
            pcwr    = 1'b1;
            npc_sel = NPC_RS;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected cycle traces built from the
// instruction rules, replayed against the DUT with a full compare every cycle.
module tb_mc_ctrl;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXE_R = 3, S_EXE_I = 4,
                  S_MEMADR = 5, S_MEMRD = 6, S_MEMWR = 7, S_WB_ALU = 8, S_WB_MEM = 9,
                  S_BRANCH = 10, S_JUMP = 11, S_JR = 12;
   localparam int TMO = 15;

   localparam logic [5:0] O_R = 6'b000000, O_ORI = 6'b001101, O_LUI = 6'b001111,
                          O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100,
                          O_J = 6'b000010, O_JAL = 6'b000011, O_BAD = 6'b111111;
   localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000,
                          F_ADD = 6'b100000;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_rd;
      logic       mem_wr;
      logic       irwr;
      logic       pcwr;
      logic [1:0] npc;
      logic       regwr;
      logic [1:0] regdst;
      logic [1:0] m2r;
      logic       extcon;
      logic       alusrc;
      logic [2:0] aluop;
      logic       err;
   } outs_t;

   typedef struct {
      logic       rdy;
      logic       z;
      logic [5:0] op;
      logic [5:0] fn;
      outs_t      e;
      string      tag;
   } cyc_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       mem_rd, mem_wr, irwr, pcwr, regwr, extcon, alusrc, err;
   logic [1:0] npc_sel, regdst, memtoreg;
   logic [2:0] aluop;
   logic [3:0] state;
   outs_t      act;

   cyc_t       q[$];
   int         total = 0;
   int         bad   = 0;
   logic [5:0] cur_op, cur_fn;
   string      cur_tag;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .irwr(irwr),
      .pcwr(pcwr), .npc_sel(npc_sel), .regwr(regwr), .regdst(regdst),
      .memtoreg(memtoreg), .extcon(extcon), .alusrc(alusrc), .aluop(aluop),
      .err(err), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {state, mem_rd, mem_wr, irwr, pcwr, npc_sel, regwr, regdst,
                 memtoreg, extcon, alusrc, aluop, err};

   task automatic check(string tag, outs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got vec=%h state=%0d, want vec=%h state=%0d",
                  tag, act, act.st, exp, exp.st);
      end
   endtask

   task automatic pin(string tag, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL model %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic outs_t blank(int st);
      outs_t e;
      e    = '0;
      e.st = st[3:0];
      return e;
   endfunction

   function automatic logic nz();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(outs_t e, logic rdy, logic z);
      cyc_t c;
      c.rdy = rdy;
      c.z   = z;
      c.op  = cur_op;
      c.fn  = cur_fn;
      c.e   = e;
      c.tag = $sformatf("%s#%0d", cur_tag, q.size());
      q.push_back(c);
   endtask

   // fetch with 'waits' not-ready cycles; every 15th consecutive one aborts and retries
   task automatic fetch(int waits);
      outs_t e;
      int    cnt = 0;
      for (int i = 0; i < waits; i++) begin
         e = blank(S_FETCH);
         e.mem_rd = 1'b1;
         cnt++;
         if (cnt == TMO) begin
            e.err = 1'b1;
            cnt   = 0;
         end
         push(e, 1'b0, nz());
      end
      e = blank(S_FETCH);
      e.mem_rd = 1'b1;
      e.irwr   = 1'b1;
      e.pcwr   = 1'b1;
      push(e, 1'b1, nz());
   endtask

   task automatic mem_wait(int st, int waits, output bit aborted);
      outs_t e;
      aborted = 1'b0;
      e = blank(st);
      if (st == S_MEMRD) e.mem_rd = 1'b1;
      else               e.mem_wr = 1'b1;
      for (int i = 1; i <= waits; i++) begin
         if (i == TMO) begin
            e.err = 1'b1;
            push(e, 1'b0, nz());
            aborted = 1'b1;
            return;
         end
         push(e, 1'b0, nz());
      end
      push(e, 1'b1, nz());
   endtask

   task automatic instr(string tag, logic [5:0] o, logic [5:0] f, int fw, int mw, logic z);
      outs_t e;
      bit    ab;
      bit    r, addu, subu, jr, ori, lui, lw, sw, beq, j, jal, ill;
      cur_op = o; cur_fn = f; cur_tag = tag;
      r = (o == O_R);
      addu = r && f == F_ADDU; subu = r && f == F_SUBU; jr = r && f == F_JR;
      ori = o == O_ORI; lui = o == O_LUI; lw = o == O_LW; sw = o == O_SW;
      beq = o == O_BEQ; j = o == O_J; jal = o == O_JAL;
      ill = !(addu || subu || jr || ori || lui || lw || sw || beq || j || jal);
      fetch(fw);
      e = blank(S_DECODE);
      e.extcon = lw || sw || beq;
      e.err    = ill;
      push(e, nz(), nz());
      if (ill) return;
      if (addu || subu) begin
         e = blank(S_EXE_R);  e.aluop = subu ? 3'd1 : 3'd0;       push(e, nz(), nz());
         e = blank(S_WB_ALU); e.regwr = 1'b1; e.regdst = 2'd1;     push(e, nz(), nz());
      end else if (ori || lui) begin
         e = blank(S_EXE_I);  e.alusrc = 1'b1; e.aluop = lui ? 3'd3 : 3'd2; push(e, nz(), nz());
         e = blank(S_WB_ALU); e.regwr = 1'b1;                       push(e, nz(), nz());
      end else if (lw || sw) begin
         e = blank(S_MEMADR); e.alusrc = 1'b1; e.extcon = 1'b1;     push(e, nz(), nz());
         mem_wait(lw ? S_MEMRD : S_MEMWR, mw, ab);
         if (lw && !ab) begin
            e = blank(S_WB_MEM); e.regwr = 1'b1; e.m2r = 2'd1;      push(e, nz(), nz());
         end
      end else if (beq) begin
         e = blank(S_BRANCH);
         e.aluop = 3'd1; e.extcon = 1'b1; e.npc = 2'd1; e.pcwr = z;
         push(e, nz(), z);
      end else if (j || jal) begin
         e = blank(S_JUMP); e.pcwr = 1'b1; e.npc = 2'd2;
         if (jal) begin
            e.regwr = 1'b1; e.regdst = 2'd2; e.m2r = 2'd2;
         end
         push(e, nz(), nz());
      end else begin
         e = blank(S_JR); e.pcwr = 1'b1; e.npc = 2'd3;              push(e, nz(), nz());
      end
   endtask

   task automatic run_queue();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         mem_ready = c.rdy;
         zero      = c.z;
         op        = c.op;
         funct     = c.fn;
         @(negedge clk);
         check(c.tag, c.e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      outs_t e;
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", blank(S_IDLE));
      reset = 1'b0;
      #1 check("idle", blank(S_IDLE));

      // ori with two fetch wait cycles: FETCH x3, DECODE, EXE_I, WB_ALU
      instr("ori", O_ORI, 6'd0, 2, 0, 1'b0);
      pin("ori len", q.size(), 6);
      pin("ori dec extcon", int'(q[3].e.extcon), 0);
      pin("ori exe aluop", int'(q[4].e.aluop), 2);
      pin("ori wb regdst", int'(q[5].e.regdst), 0);
      run_queue();
      instr("lui", O_LUI, 6'd0, 0, 0, 1'b0);      run_queue();
      instr("addu", O_R, F_ADDU, 0, 0, 1'b0);
      pin("addu len", q.size(), 4);
      run_queue();
      instr("subu", O_R, F_SUBU, 1, 0, 1'b0);     run_queue();
      instr("lw", O_LW, 6'd0, 0, 0, 1'b0);
      pin("lw len", q.size(), 5);
      pin("lw wb m2r", int'(q[4].e.m2r), 1);
      run_queue();
      instr("lw_w3", O_LW, 6'd0, 0, 3, 1'b0);     run_queue();
      instr("sw", O_SW, 6'd0, 0, 0, 1'b0);
      pin("sw len", q.size(), 4);
      run_queue();
      instr("sw_w2", O_SW, 6'd0, 1, 2, 1'b0);     run_queue();
      instr("beq_t", O_BEQ, 6'd0, 0, 0, 1'b1);
      pin("beq len", q.size(), 3);
      pin("beq taken pcwr", int'(q[2].e.pcwr), 1);
      run_queue();
      instr("beq_nt", O_BEQ, 6'd0, 0, 0, 1'b0);   run_queue();
      instr("j", O_J, 6'd0, 0, 0, 1'b0);          run_queue();
      instr("jal", O_JAL, 6'd0, 0, 0, 1'b0);
      pin("jal regdst", int'(q[2].e.regdst), 2);
      run_queue();
      instr("jr", O_R, F_JR, 0, 0, 1'b0);         run_queue();
      instr("bad_op", O_BAD, 6'd0, 0, 0, 1'b0);
      pin("bad_op len", q.size(), 2);
      run_queue();
      instr("bad_fn", O_R, F_ADD, 0, 0, 1'b0);    run_queue();
      instr("sw_tmo", O_SW, 6'd0, 0, 20, 1'b0);
      pin("sw_tmo len", q.size(), 18);
      pin("sw_tmo err", int'(q[17].e.err), 1);
      pin("sw_tmo pcwr", int'(q[17].e.pcwr), 0);
      run_queue();
      instr("lw_tmo", O_LW, 6'd0, 0, 15, 1'b0);   run_queue();
      instr("fetch_tmo", O_ORI, 6'd0, 16, 0, 1'b0); run_queue();

      // lw up to the first MEMRD stall cycle, then reset mid-access
      cur_op = O_LW; cur_fn = 6'd0; cur_tag = "rst_lw";
      fetch(0);
      e = blank(S_DECODE); e.extcon = 1'b1;                 push(e, 1'b0, 1'b0);
      e = blank(S_MEMADR); e.alusrc = 1'b1; e.extcon = 1'b1; push(e, 1'b0, 1'b0);
      e = blank(S_MEMRD);  e.mem_rd = 1'b1;                 push(e, 1'b0, 1'b0);
      run_queue();
      #1;
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1 check("rst_async", blank(S_IDLE));
      @(posedge clk);
      #1 check("rst_hold", blank(S_IDLE));
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1 check("rst_idle", blank(S_IDLE));
      // counter must start from zero again: abort lands on the 15th stall
      instr("post_rst", O_ORI, 6'd0, 16, 0, 1'b0); run_queue();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
